// File: rtl/insn_prefetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | insn_prefetch_pkg                                                      |
// | Shared types and bus request codes for the instruction prefetch queue. |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
package insn_prefetch_pkg;

  // Bus request codes shared with the cache and the system bus
  localparam logic [2:0] c_BR_NONE = 3'b000;
  localparam logic [2:0] c_BR_READ = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [15:0] insn;
  } fifo_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return pc & 32'hFFFF_FFFE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/insn_prefetch_fifo.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | prefetch_fifo                                                          |
// | Synchronous FIFO with push/pop/flush; only pointers and count reset.   |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module prefetch_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW-1:0] c_PTR_ONE = PW'(1);
  localparam logic [PW:0]   c_CNT_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr_q, w_wr_ptr_d;
  logic [PW-1:0]    r_rd_ptr_q, w_rd_ptr_d;
  logic [PW:0]      r_count_q,  w_count_d;
  logic             w_do_pop;

  assign w_do_pop = i_pop && (r_count_q != '0);

  always_comb begin
    w_wr_ptr_d = r_wr_ptr_q;
    w_rd_ptr_d = r_rd_ptr_q;
    w_count_d  = r_count_q;
    if (i_flush) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end else begin
      if (i_push)   w_wr_ptr_d = r_wr_ptr_q + c_PTR_ONE;
      if (w_do_pop) w_rd_ptr_d = r_rd_ptr_q + c_PTR_ONE;
      case ({i_push, w_do_pop})
        2'b10:   w_count_d = r_count_q + c_CNT_ONE;
        2'b01:   w_count_d = r_count_q - c_CNT_ONE;
        default: w_count_d = r_count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr_q <= '0;
      r_rd_ptr_q <= '0;
      r_count_q  <= '0;
    end else begin
      r_wr_ptr_q <= w_wr_ptr_d;
      r_rd_ptr_q <= w_rd_ptr_d;
      r_count_q  <= w_count_d;
    end
  end

  // Storage is deliberately left unreset; its contents are don't-care while empty
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr_q] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr_q];
  assign o_count = r_count_q;

endmodule
`default_nettype wire

// File: rtl/insn_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | insn_prefetch                                                          |
// | Halfword fetch engine feeding the decoder through a prefetch FIFO.     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module insn_prefetch
  import insn_prefetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                    CLK,
  input  logic                    nRESET,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [31:0]             ic_addr,
  output logic [2:0]              ic_br,
  input  logic [15:0]             ic_data,
  input  logic                    ic_compl,
  output logic                    dec_valid,
  output logic [15:0]             dec_insn,
  output logic [31:0]             dec_pc,
  input  logic                    dec_ready,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;
  // A request may start while at least one slot is free for its data
  localparam logic [LW-1:0] c_LVL_ISSUE_MAX = LW'(DEPTH - 1);

  state_e      r_state_q,    w_state_d;
  logic [31:0] r_fetch_pc_q, w_fetch_pc_d;
  logic [31:0] r_ic_addr_q,  w_ic_addr_d;
  logic [2:0]  r_ic_br_q,    w_ic_br_d;
  logic        r_discard_q,  w_discard_d;
  logic        w_push;
  logic        w_pop;
  fifo_entry_t w_push_entry;
  fifo_entry_t w_head;

  always_comb begin
    w_state_d    = r_state_q;
    w_fetch_pc_d = r_fetch_pc_q;
    w_ic_addr_d  = r_ic_addr_q;
    w_ic_br_d    = r_ic_br_q;
    w_discard_d  = r_discard_q;
    w_push       = 1'b0;
    case (r_state_q)
      ST_IDLE: begin
        // Hold off on a redirect cycle so the stale PC is never requested
        if (!redirect && (level <= c_LVL_ISSUE_MAX) && !ic_compl) begin
          w_ic_addr_d = r_fetch_pc_q;
          w_ic_br_d   = c_BR_READ;
          w_state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (ic_compl) begin
          w_ic_br_d = c_BR_NONE;
          if (!r_discard_q && !redirect) begin
            w_push       = 1'b1;
            w_fetch_pc_d = r_fetch_pc_q + 32'd2;
          end
          w_state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        w_ic_br_d = c_BR_NONE;
        if (!ic_compl) begin
          w_discard_d = 1'b0;
          w_state_d   = ST_IDLE;
        end
      end
      default: begin
        w_ic_br_d = c_BR_NONE;
        w_state_d = ST_IDLE;
      end
    endcase
    if (redirect) begin
      w_fetch_pc_d = align_pc(redirect_pc);
      if (r_state_q == ST_REQ && !ic_compl) w_discard_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      r_state_q    <= ST_IDLE;
      r_fetch_pc_q <= align_pc(RESET_PC);
      r_ic_addr_q  <= '0;
      r_ic_br_q    <= c_BR_NONE;
      r_discard_q  <= 1'b0;
    end else begin
      r_state_q    <= w_state_d;
      r_fetch_pc_q <= w_fetch_pc_d;
      r_ic_addr_q  <= w_ic_addr_d;
      r_ic_br_q    <= w_ic_br_d;
      r_discard_q  <= w_discard_d;
    end
  end

  assign w_push_entry = '{pc: r_fetch_pc_q, insn: ic_data};
  assign w_pop        = dec_valid && dec_ready && !redirect;

  prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (48)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (nRESET),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_head),
    .o_count (level)
  );

  assign ic_addr   = r_ic_addr_q;
  assign ic_br     = r_ic_br_q;
  assign dec_valid = (level != '0);
  assign dec_insn  = w_head.insn;
  assign dec_pc    = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_insn_prefetch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_insn_prefetch                                                       |
// | Self-checking bench: cache responder, queue-based reference model.     |
// | Revision: 1.0                                                          |
// +-----------------------------------------------------------------------+
module tb_insn_prefetch;
  import insn_prefetch_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_1000;

  logic                   CLK = 1'b0;
  logic                   nRESET = 1'b0;
  logic                   redirect = 1'b0;
  logic [31:0]            redirect_pc = '0;
  logic [31:0]            ic_addr;
  logic [2:0]             ic_br;
  logic [15:0]            ic_data = '0;
  logic                   ic_compl = 1'b0;
  logic                   dec_valid;
  logic [15:0]            dec_insn;
  logic [31:0]            dec_pc;
  logic                   dec_ready = 1'b0;
  logic [$clog2(DEPTH):0] level;

  always #5 CLK = ~CLK;

  insn_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .CLK(CLK), .nRESET(nRESET), .redirect(redirect), .redirect_pc(redirect_pc),
    .ic_addr(ic_addr), .ic_br(ic_br), .ic_data(ic_data), .ic_compl(ic_compl),
    .dec_valid(dec_valid), .dec_insn(dec_insn), .dec_pc(dec_pc),
    .dec_ready(dec_ready), .level(level)
  );

  typedef struct packed { logic [31:0] pc; logic [15:0] insn; } ent_t;
  typedef struct { logic [31:0] rpc; int lat; logic [31:0] e0; logic [31:0] e1; logic [31:0] e2; } vec_t;

  int          vectors = 0;
  int          miscompares = 0;
  ent_t        exp_q[$];
  logic [31:0] popped[$];
  logic [31:0] model_pc = RESET_PC;
  bit          req_stale = 1'b0;
  bit          c_busy = 1'b0;
  bit          compl_first = 1'b0;
  bit          rand_lat = 1'b0;
  int          c_cnt = 0;
  int          c_hold = 0;
  int          lat = 3;
  int          hold_max = 1;
  int          n_req = 0;
  logic [31:0] c_addr = '0;
  vec_t        tbl[5];

  function automatic logic [15:0] insn_of(input logic [31:0] a);
    return a[16:1] ^ a[31:16] ^ 16'h5A3C;
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: compare at the negedge, run the cache, advance the model, cross the edge
  task automatic step();
    check("dec_valid", {47'd0, dec_valid}, {47'd0, exp_q.size() != 0});
    check("level", {44'd0, level}, 48'(exp_q.size()));
    if (exp_q.size() != 0) begin
      check("dec_pc", {16'd0, dec_pc}, {16'd0, exp_q[0].pc});
      check("dec_insn", {32'd0, dec_insn}, {32'd0, exp_q[0].insn});
    end
    if (level >= 4'(DEPTH)) check("br_while_full", {45'd0, ic_br}, {45'd0, c_BR_NONE});

    compl_first = 1'b0;
    if (ic_compl) begin
      c_hold--;
      if (c_hold == 0) ic_compl = 1'b0;
    end else if (c_busy) begin
      if (ic_br == c_BR_READ) check("ic_addr_stable", {16'd0, ic_addr}, {16'd0, c_addr});
      c_cnt--;
    end else if (ic_br == c_BR_READ) begin
      n_req++;
      c_addr = ic_addr;
      req_stale = 1'b0;
      check("ic_addr", {16'd0, ic_addr}, {16'd0, model_pc});
      if (rand_lat) lat = $urandom_range(1, 4);
      c_busy = 1'b1;
      c_cnt = lat - 1;
    end
    if (c_busy && c_cnt == 0) begin
      c_busy = 1'b0;
      ic_compl = 1'b1;
      ic_data = insn_of(c_addr);
      c_hold = $urandom_range(1, hold_max);
      compl_first = 1'b1;
    end

    if (exp_q.size() != 0 && dec_ready && !redirect && nRESET) begin
      popped.push_back(dec_pc);
      void'(exp_q.pop_front());
    end
    if (compl_first && !req_stale && !redirect && nRESET) begin
      exp_q.push_back({model_pc, insn_of(model_pc)});
      model_pc = model_pc + 32'd2;
    end
    if (redirect) begin
      exp_q.delete();
      model_pc = redirect_pc & 32'hFFFF_FFFE;
      if (c_busy || compl_first) req_stale = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_until_popped(input int n, input int bound, input string name);
    int i = 0;
    while (popped.size() < n && i < bound) begin
      step();
      i++;
    end
    if (popped.size() < n) check(name, 48'(popped.size()), 48'(n));
  endtask

  task automatic expect_popped(input int idx, input logic [31:0] exp, input string name);
    if (idx < popped.size()) check(name, {16'd0, popped[idx]}, {16'd0, exp});
    else check(name, 48'(popped.size()), 48'(idx + 1));
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect = 1'b1;
    step();
    redirect = 1'b0;
  endtask

  initial begin
    int i;
    int n0;
    tbl[0] = '{32'h0000_2001, 1, 32'h0000_2000, 32'h0000_2002, 32'h0000_2004};
    tbl[1] = '{32'hFFFF_FFFC, 3, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0000_0000};
    tbl[2] = '{32'hFFFF_FFFF, 2, 32'hFFFF_FFFE, 32'h0000_0000, 32'h0000_0002};
    tbl[3] = '{32'h0000_0ABF, 4, 32'h0000_0ABE, 32'h0000_0AC0, 32'h0000_0AC2};
    tbl[4] = '{32'h8000_0000, 3, 32'h8000_0000, 32'h8000_0002, 32'h8000_0004};

    @(negedge CLK);
    check("rst_ic_br", {45'd0, ic_br}, {45'd0, c_BR_NONE});
    check("rst_ic_addr", {16'd0, ic_addr}, 48'd0);
    check("rst_dec_valid", {47'd0, dec_valid}, 48'd0);
    check("rst_level", {44'd0, level}, 48'd0);
    step();
    nRESET = 1'b1;
    dec_ready = 1'b1;

    // Straight-line fetch from RESET_PC, then redirect while 1006 is outstanding
    i = 0;
    while (!(c_busy && c_addr == 32'h1006) && i < 200) begin step(); i++; end
    check("reach_req_1006", {16'd0, c_addr}, {16'd0, 32'h1006});
    expect_popped(0, 32'h1000, "seq_pc0");
    expect_popped(1, 32'h1002, "seq_pc1");
    expect_popped(2, 32'h1004, "seq_pc2");
    popped.delete();
    pulse_redirect(32'h0000_2001);
    run_until_popped(1, 100, "redir_timeout");
    expect_popped(0, 32'h2000, "redir_first_pc");

    // Table of redirect targets, including wrap across 2^32
    for (int k = 0; k < 5; k++) begin
      lat = tbl[k].lat;
      popped.delete();
      pulse_redirect(tbl[k].rpc);
      run_until_popped(3, 300, "tbl_timeout");
      expect_popped(0, tbl[k].e0, "tbl_pc0");
      expect_popped(1, tbl[k].e1, "tbl_pc1");
      expect_popped(2, tbl[k].e2, "tbl_pc2");
    end

    // Decoder stalled: fill to DEPTH, then resume at the next PC
    lat = 3;
    dec_ready = 1'b0;
    popped.delete();
    pulse_redirect(32'h0000_3000);
    n0 = n_req;
    for (int k = 0; k < 70; k++) step();
    check("full_level", {44'd0, level}, 48'(DEPTH));
    check("full_requests", 48'(n_req - n0), 48'(DEPTH));
    dec_ready = 1'b1;
    run_until_popped(DEPTH + 1, 300, "resume_timeout");
    expect_popped(0, 32'h3000, "resume_pc0");
    expect_popped(DEPTH, 32'h3000 + 32'(2 * DEPTH), "resume_next_pc");

    // Redirect coincident with a completion and a pop
    dec_ready = 1'b0;
    for (int k = 0; k < 20; k++) step();
    dec_ready = 1'b1;
    i = 0;
    while (!(c_busy && c_cnt == 1) && i < 50) begin step(); i++; end
    check("coinc_valid", {47'd0, dec_valid}, 48'd1);
    popped.delete();
    pulse_redirect(32'h0000_4000);
    check("coinc_level", {44'd0, level}, 48'd0);
    check("coinc_dec_valid", {47'd0, dec_valid}, 48'd0);
    run_until_popped(1, 100, "coinc_timeout");
    expect_popped(0, 32'h4000, "coinc_first_pc");

    // Asynchronous reset in the middle of a request
    i = 0;
    while (!c_busy && i < 50) begin step(); i++; end
    #2 nRESET = 1'b0;
    #1;
    check("arst_ic_br", {45'd0, ic_br}, {45'd0, c_BR_NONE});
    check("arst_dec_valid", {47'd0, dec_valid}, 48'd0);
    check("arst_level", {44'd0, level}, 48'd0);
    exp_q.delete();
    model_pc = RESET_PC;
    req_stale = 1'b1;
    @(negedge CLK);
    for (int k = 0; k < 8; k++) step();
    nRESET = 1'b1;
    popped.delete();
    run_until_popped(2, 100, "arst_timeout");
    expect_popped(0, RESET_PC, "arst_restart_pc");
    expect_popped(1, RESET_PC + 32'd2, "arst_restart_pc1");

    // Randomized traffic against the queue model
    rand_lat = 1'b1;
    hold_max = 2;
    for (int k = 0; k < 3000; k++) begin
      dec_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF)) : $urandom();
        redirect = 1'b1;
      end
      step();
      redirect = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
